// File: rtl/cv32e40p_tmr_fault_manager_if.sv
// Signal bundle between the TMR voter/pipeline side and the fault manager.
// The master drives the mismatch flags and swap handshake; the slave is the manager.
interface cv32e40p_tmr_fault_manager_if;
  logic       err_valid_i;
  logic [2:0] err_pos_i;
  logic       clear_i;
  logic       swap_ack_i;
  logic       swap_req_o;
  logic [2:0] spare_sel_o;
  logic [2:0] faulted_o;
  logic       fatal_o;
  logic [1:0] state_o;

  modport master (
    output err_valid_i, err_pos_i, clear_i, swap_ack_i,
    input  swap_req_o, spare_sel_o, faulted_o, fatal_o, state_o
  );

  modport slave (
    input  err_valid_i, err_pos_i, clear_i, swap_ack_i,
    output swap_req_o, spare_sel_o, faulted_o, fatal_o, state_o
  );
endinterface

// File: rtl/cv32e40p_tmr_fault_manager.sv
// Counts persistent voter disagreements per ALU replica and retires a faulty
// position to the single spare after a quiescence handshake with the pipeline.
module cv32e40p_tmr_fault_manager #(
  parameter int THRESHOLD = 2,
  parameter int CNT_W     = 16,
  parameter int DECAY_WIN = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cv32e40p_tmr_fault_manager_if.slave   bus
);

  localparam logic [1:0] NORMAL    = 2'd0;
  localparam logic [1:0] SWAP_WAIT = 2'd1;
  localparam logic [1:0] SPARE     = 2'd2;
  localparam logic [1:0] FATAL     = 2'd3;

  localparam int             DW    = (DECAY_WIN < 2) ? 1 : $clog2(DECAY_WIN + 1);
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);
  localparam logic [DW-1:0]  DLAST = DW'((DECAY_WIN > 0) ? DECAY_WIN - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [1:0]       victim_q, victim_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       faulted_q, faulted_d;
  logic             req_q, req_d;
  logic             fatal_q, fatal_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [CNT_W-1:0] cnt_inc [3];
  logic [DW-1:0]    dcnt_q, dcnt_d;

  logic             count_en;
  logic [2:0]       hit;
  logic [2:0]       victim_oh;
  logic [1:0]       n_hits;
  logic [1:0]       hit_idx;

  // A hit is a saturating increment that lands on THRESHOLD in this very edge.
  always_comb begin
    count_en = bus.err_valid_i && (state_q != FATAL) && !bus.clear_i;
    for (int i = 0; i < 3; i++) begin
      cnt_inc[i] = (cnt_q[i] == THR) ? THR : cnt_q[i] + CNT_W'(1);
      hit[i]     = count_en && bus.err_pos_i[i] && (cnt_inc[i] == THR);
    end
    n_hits    = 2'(hit[0]) + 2'(hit[1]) + 2'(hit[2]);
    hit_idx   = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);
    victim_oh = 3'b001 << victim_q;
  end

  always_comb begin
    state_d   = state_q;
    victim_d  = victim_q;
    sel_d     = sel_q;
    faulted_d = faulted_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;

    if (bus.clear_i) begin
      for (int i = 0; i < 3; i++) cnt_d[i] = '0;
      dcnt_d = '0;
    end else if (count_en) begin
      for (int i = 0; i < 3; i++) begin
        if (bus.err_pos_i[i]) cnt_d[i] = cnt_inc[i];
      end
      if (bus.err_pos_i != 3'b000) begin
        dcnt_d = '0;
      end else if (DECAY_WIN != 0) begin
        if (dcnt_q == DLAST) begin
          // A waiting victim keeps its saturated count until the swap lands.
          for (int i = 0; i < 3; i++) begin
            if (!(state_q == SWAP_WAIT && 2'(i) == victim_q)) cnt_d[i] = '0;
          end
          dcnt_d = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
    end

    case (state_q)
      NORMAL: begin
        if (n_hits >= 2'd2) begin
          state_d = FATAL;
        end else if (hit != 3'b000) begin
          state_d  = SWAP_WAIT;
          victim_d = hit_idx;
          req_d    = 1'b1;
        end
      end
      SWAP_WAIT: begin
        if ((hit & ~victim_oh) != 3'b000) begin
          state_d = FATAL;
          req_d   = 1'b0;
        end else if (bus.swap_ack_i) begin
          state_d          = SPARE;
          sel_d            = sel_q | victim_oh;
          faulted_d        = faulted_q | victim_oh;
          cnt_d[victim_q]  = '0;
          dcnt_d           = '0;
          req_d            = 1'b0;
        end
      end
      SPARE: begin
        if (hit != 3'b000) state_d = FATAL;
      end
      default: begin
        req_d = 1'b0;
      end
    endcase

    fatal_d = (state_d == FATAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NORMAL;
      victim_q  <= 2'd0;
      sel_q     <= 3'b000;
      faulted_q <= 3'b000;
      req_q     <= 1'b0;
      fatal_q   <= 1'b0;
      dcnt_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      victim_q  <= victim_d;
      sel_q     <= sel_d;
      faulted_q <= faulted_d;
      req_q     <= req_d;
      fatal_q   <= fatal_d;
      dcnt_q    <= dcnt_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.swap_req_o  = req_q;
  assign bus.spare_sel_o = sel_q;
  assign bus.faulted_o   = faulted_q;
  assign bus.fatal_o     = fatal_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Bench for the TMR fault manager: directed scenarios plus random traffic,
// all outputs compared against a rule-level reference model every cycle.
module tb_cv32e40p_tmr_fault_manager;

  localparam int THR  = 2;
  localparam int DWIN = 4;

  logic clk;
  logic rst_n;

  cv32e40p_tmr_fault_manager_if bus();

  cv32e40p_tmr_fault_manager #(
    .THRESHOLD (THR),
    .CNT_W     (16),
    .DECAY_WIN (DWIN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int       m_cnt [3];
  int       m_dec;
  int       m_state;
  int       m_victim;
  bit [2:0] m_sel;
  bit [2:0] m_faulted;
  bit       m_req;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_state"},   32'(bus.state_o),     32'(m_state));
    checkOutput({tag, "_req"},     32'(bus.swap_req_o),  32'(m_req));
    checkOutput({tag, "_sel"},     32'(bus.spare_sel_o), 32'(m_sel));
    checkOutput({tag, "_faulted"}, 32'(bus.faulted_o),   32'(m_faulted));
    checkOutput({tag, "_fatal"},   32'(bus.fatal_o),     32'(m_state == 3));
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_dec = 0; m_state = 0; m_victim = 0;
    m_sel = 0; m_faulted = 0; m_req = 0;
  endtask

  // Rule-level model: 0 NORMAL, 1 SWAP_WAIT, 2 SPARE, 3 FATAL.
  task automatic modelStep(input bit v, input bit [2:0] p, input bit c, input bit a);
    bit [2:0] hits = 3'b000;
    bit [2:0] others;
    if (c) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_dec = 0;
    end else if (v && m_state != 3) begin
      for (int i = 0; i < 3; i++) begin
        if (p[i]) begin
          if (m_cnt[i] < THR) m_cnt[i]++;
          if (m_cnt[i] == THR) hits[i] = 1'b1;
        end
      end
      if (p != 0) m_dec = 0;
      else begin
        m_dec++;
        if (m_dec == DWIN) begin
          for (int i = 0; i < 3; i++)
            if (!(m_state == 1 && i == m_victim)) m_cnt[i] = 0;
          m_dec = 0;
        end
      end
    end
    others = hits;
    others[m_victim] = 1'b0;
    case (m_state)
      0: if ($countones(hits) >= 2) m_state = 3;
         else if (hits != 0) begin
           m_state = 1; m_req = 1;
           for (int i = 2; i >= 0; i--) if (hits[i]) m_victim = i;
         end
      1: if (others != 0) begin m_state = 3; m_req = 0; end
         else if (a) begin
           m_sel[m_victim] = 1; m_faulted[m_victim] = 1;
           m_cnt[m_victim] = 0; m_dec = 0; m_req = 0; m_state = 2;
         end
      2: if (hits != 0) m_state = 3;
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input bit v, input bit [2:0] p, input bit c, input bit a, input string tag);
    bus.err_valid_i = v; bus.err_pos_i = p; bus.clear_i = c; bus.swap_ack_i = a;
    @(posedge clk);
    modelStep(v, p, c, a);
    #1;
    checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    bus.err_valid_i = 0; bus.err_pos_i = 0; bus.clear_i = 0; bus.swap_ack_i = 0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    modelStep(0, 0, 0, 0);
    #1;
    checkAll({tag, "_rel"});
  endtask

  initial begin
    rst_n = 1'b1;
    bus.err_valid_i = 0; bus.err_pos_i = 0; bus.clear_i = 0; bus.swap_ack_i = 0;
    modelReset();
    @(posedge clk);
    #1;
    doReset("rst0");

    applyStimulus(1, 3'b010, 0, 0, "swap_e1");
    applyStimulus(1, 3'b010, 0, 0, "swap_e2");
    checkOutput("tp_wait_state", 32'(bus.state_o), 32'd1);
    applyStimulus(1, 3'b000, 0, 1, "swap_ack");
    checkOutput("tp_spare_sel", 32'(bus.spare_sel_o), 32'b010);
    applyStimulus(1, 3'b001, 0, 0, "spare_e1");
    applyStimulus(1, 3'b001, 0, 0, "spare_e2");
    checkOutput("tp_spare_fatal_sel", 32'(bus.spare_sel_o), 32'b010);
    applyStimulus(1, 3'b000, 0, 1, "fatal_ack");
    doReset("rst_fatal");

    applyStimulus(1, 3'b001, 0, 0, "dec_e");
    for (int i = 0; i < DWIN; i++) applyStimulus(1, 3'b000, 0, 0, "dec_clean");
    applyStimulus(1, 3'b001, 0, 0, "dec_e2");
    checkOutput("tp_decay_state", 32'(bus.state_o), 32'd0);
    doReset("rst_dec");

    applyStimulus(1, 3'b101, 0, 0, "sim_e1");
    applyStimulus(1, 3'b101, 0, 0, "sim_e2");
    checkOutput("tp_sim_fatal", 32'(bus.fatal_o), 32'd1);
    doReset("rst_sim");

    applyStimulus(1, 3'b001, 0, 0, "sw_e1");
    applyStimulus(1, 3'b001, 0, 0, "sw_e2");
    applyStimulus(1, 3'b100, 0, 0, "sw_o1");
    applyStimulus(1, 3'b100, 0, 0, "sw_o2");
    checkOutput("tp_wait_fatal_sel", 32'(bus.spare_sel_o), 32'b000);
    doReset("rst_sw");

    applyStimulus(1, 3'b100, 0, 0, "clr_e1");
    applyStimulus(1, 3'b100, 1, 0, "clr_clr");
    applyStimulus(1, 3'b100, 0, 0, "clr_e2");
    checkOutput("tp_clr_state", 32'(bus.state_o), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 3'b111, 0, 1, "novalid");

    for (int r = 0; r < 25; r++) begin
      doReset("rnd_rst");
      for (int k = 0; k < 40; k++) begin
        bit       v = ($urandom_range(0, 4) != 0);
        bit [2:0] p = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
        bit       c = ($urandom_range(0, 15) == 0);
        bit       a = ($urandom_range(0, 3) == 0);
        applyStimulus(v, p, c, a, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
